// File: rtl/snax_gemm_pkg.sv
// Shared types for the snax_gemm TCDM read streamer: FSM states, TCDM request/response structs.
// Constant-only package; no timing or flow control of its own.
package snax_gemm_pkg;

    localparam int unsigned TcdmAddrWidth = 48;
    localparam int unsigned TcdmDataWidth = 64;
    localparam int unsigned BytesPerPort  = TcdmDataWidth / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } gemm_rd_state_e;

    typedef struct packed {
        logic [TcdmAddrWidth-1:0]  addr;
        logic                      write;
        logic [TcdmDataWidth-1:0]  data;
        logic [BytesPerPort-1:0]   strb;
        logic                      user;
    } tcdm_req_chan_t;

    typedef struct packed {
        tcdm_req_chan_t q;
        logic           q_valid;
    } snax_tcdm_req_t;

    typedef struct packed {
        logic [TcdmDataWidth-1:0] data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        logic           q_ready;
        tcdm_rsp_chan_t p;
        logic           p_valid;
    } snax_tcdm_rsp_t;

endpackage

// File: rtl/snax_gemm_tcdm_port_ctrl.sv
// One TCDM port of the read streamer: holds q_valid until granted, then captures one response.
// Grant/got are also reported combinationally so the parent FSM can advance on the same edge.
module snax_gemm_tcdm_port_ctrl
    import snax_gemm_pkg::*;
#(
    parameter int unsigned DataWidth = TcdmDataWidth
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start_beat,
    input  logic                 i_q_ready,
    input  logic                 i_p_valid,
    input  logic [DataWidth-1:0] i_p_data,
    output logic                 o_q_valid,
    output logic                 o_granted,
    output logic                 o_got,
    output logic [DataWidth-1:0] o_data
);

    logic                 r_pend;
    logic                 r_granted;
    logic                 r_got;
    logic [DataWidth-1:0] r_data;
    logic                 w_grant;
    logic                 w_capture;

    assign w_grant   = r_pend & i_q_ready;
    // Only the single response belonging to the granted request is taken.
    assign w_capture = r_granted & ~r_got & i_p_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend    <= 1'b0;
            r_granted <= 1'b0;
            r_got     <= 1'b0;
            r_data    <= '0;
        end else if (i_start_beat) begin
            r_pend    <= 1'b1;
            r_granted <= 1'b0;
            r_got     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_pend    <= 1'b0;
                r_granted <= 1'b1;
            end
            if (w_capture) begin
                r_got  <= 1'b1;
                r_data <= i_p_data;
            end
        end
    end

    assign o_q_valid = r_pend;
    assign o_granted = r_granted | w_grant;
    assign o_got     = r_got | w_capture;
    assign o_data    = r_data;

    a_no_unsolicited_rsp: assert property (@(posedge i_clk) disable iff (i_rst)
        i_p_valid |-> (r_granted && !r_got));

endmodule

// File: rtl/snax_gemm_tcdm_reader.sv
// Read streamer feeding snax_gemm: fetches one wide beat per job step over parallel TCDM ports.
// Start to data_valid_o is 3 cycles with zero-wait TCDM; next beat is requested after the handshake.
module snax_gemm_tcdm_reader
    import snax_gemm_pkg::*;
#(
    parameter int unsigned AddrWidth     = TcdmAddrWidth,
    parameter int unsigned DataWidth     = TcdmDataWidth,
    parameter int unsigned SnaxTcdmPorts = 16,
    parameter int unsigned BeatCntWidth  = 16,
    parameter type         tcdm_req_t    = snax_tcdm_req_t,
    parameter type         tcdm_rsp_t    = snax_tcdm_rsp_t
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [AddrWidth-1:0]               base_addr_i,
    input  logic [AddrWidth-1:0]               stride_i,
    input  logic [BeatCntWidth-1:0]            num_beats_i,
    output logic                               busy_o,
    output logic                               done_o,
    output tcdm_req_t                          tcdm_req_o [SnaxTcdmPorts],
    input  tcdm_rsp_t                          tcdm_rsp_i [SnaxTcdmPorts],
    output logic [SnaxTcdmPorts*DataWidth-1:0] data_o,
    output logic                               data_valid_o,
    input  logic                               data_ready_i
);

    gemm_rd_state_e            r_state;
    gemm_rd_state_e            w_state_nxt;
    logic [AddrWidth-1:0]      r_addr;
    logic [AddrWidth-1:0]      r_stride;
    logic [BeatCntWidth-1:0]   r_num_beats;
    logic [BeatCntWidth-1:0]   r_beat;
    logic                      w_start_beat;
    logic                      w_load;
    logic                      w_advance;
    logic                      w_last;
    logic [SnaxTcdmPorts-1:0]  w_q_valid;
    logic [SnaxTcdmPorts-1:0]  w_granted;
    logic [SnaxTcdmPorts-1:0]  w_got;

    assign w_last = (r_beat == r_num_beats - BeatCntWidth'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_start_beat = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_load = 1'b1;
                    if (num_beats_i != '0) begin
                        w_state_nxt  = ST_REQ;
                        w_start_beat = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (&w_granted) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (&w_got) w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (data_ready_i) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt  = ST_REQ;
                        w_start_beat = 1'b1;
                        w_advance    = 1'b1;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_stride    <= '0;
            r_num_beats <= '0;
            r_beat      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_addr      <= base_addr_i;
                r_stride    <= stride_i;
                r_num_beats <= num_beats_i;
                r_beat      <= '0;
            end else if (w_advance) begin
                // Running accumulator keeps the beat address off any multiplier path.
                r_addr <= r_addr + r_stride;
                r_beat <= r_beat + BeatCntWidth'(1);
            end
        end
    end

    for (genvar p = 0; p < SnaxTcdmPorts; p++) begin : g_port
        snax_gemm_tcdm_port_ctrl #(
            .DataWidth (DataWidth)
        ) i_port_ctrl (
            .i_clk        (clk_i),
            .i_rst        (rst_i),
            .i_start_beat (w_start_beat),
            .i_q_ready    (tcdm_rsp_i[p].q_ready),
            .i_p_valid    (tcdm_rsp_i[p].p_valid),
            .i_p_data     (tcdm_rsp_i[p].p.data),
            .o_q_valid    (w_q_valid[p]),
            .o_granted    (w_granted[p]),
            .o_got        (w_got[p]),
            .o_data       (data_o[p*DataWidth +: DataWidth])
        );
    end

    always_comb begin
        for (int p = 0; p < SnaxTcdmPorts; p++) begin
            tcdm_req_o[p]         = '0;
            tcdm_req_o[p].q.addr  = r_addr + AddrWidth'(p * BytesPerPort);
            tcdm_req_o[p].q.strb  = '1;
            tcdm_req_o[p].q_valid = w_q_valid[p];
        end
    end

    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DONE);
    assign data_valid_o = (r_state == ST_OUT);

endmodule
